key_conditioner: RTL

Front-end input stage for the step sequencer. Takes the six raw active-low push-buttons (four cursor keys, A = set, B = clear) and synchronises and debounces them. Cursor keys auto-repeat while held. Conditioned presses are delivered as one-cycle pulses and as a serialized one-at-a-time event stream, which the sequencer's grid-edit logic consumes in place of sampling raw buttons on a slow clock.

---
 rtl/key_pkg.sv | 31 +++
 rtl/key_debounce.sv | 125 ++++++++++++
 rtl/key_conditioner.sv | 59 +++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants and types for the button front end: key indices,
// repeat FSM states and the lowest-pending-key encoder.
package key_pkg;

   localparam int KEY_N  = 6;
   localparam int CODE_W = 3;

   localparam int KEY_XDEC = 0;
   localparam int KEY_YINC = 1;
   localparam int KEY_YDEC = 2;
   localparam int KEY_XINC = 3;
   localparam int KEY_A    = 4;
   localparam int KEY_B    = 5;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   // Lower key index wins; an empty vector encodes as 0.
   function automatic logic [CODE_W-1:0] lowest_index(input logic [KEY_N-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = KEY_N - 1; i >= 0; i--) begin
         if (v[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-FF synchroniser, stability counter, auto-repeat FSM and
// registered press/release pulses. state_o exposes the repeat FSM state.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_RATE     = 2700000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n_i,
   input  logic       rpt_en_i,
   output logic       level_o,
   output logic       press_o,
   output logic       release_o,
   output logic [1:0] state_o
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] D_TERM  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RR_TERM = RW'(REPEAT_RATE - 1);

   logic [1:0]    sync_q;
   logic          key_sync;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          level_q, level_d;
   logic          rise, fall;
   logic          release_q;
   logic          press_q;
   logic [RW-1:0] rcnt_q;
   rpt_state_t    state_q;

   assign key_sync = sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[0], ~key_n_i};
   end

   // The counter only runs while the synchronised input disagrees with the
   // accepted level, so any bounce back restarts qualification.
   always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (key_sync != level_q) begin
         if (dcnt_q == D_TERM) begin
            level_d = key_sync;
            rise    = key_sync;
            fall    = ~key_sync;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         dcnt_q    <= dcnt_d;
         level_q   <= level_d;
         release_q <= fall;
      end
   end

   // Release overrides any repeat terminal count landing on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RPT_IDLE;
         rcnt_q  <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= rise;
         if (fall) begin
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
         end else begin
            case (state_q)
               RPT_IDLE: begin
                  if (rise && rpt_en_i) begin
                     state_q <= RPT_DELAY;
                     rcnt_q  <= '0;
                  end
               end
               RPT_DELAY: begin
                  if (rcnt_q == RD_TERM) begin
                     press_q <= 1'b1;
                     rcnt_q  <= '0;
                     state_q <= RPT_REPEAT;
                  end else begin
                     rcnt_q <= rcnt_q + 1'b1;
                  end
               end
               RPT_REPEAT: begin
                  if (rcnt_q == RR_TERM) begin
                     press_q <= 1'b1;
                     rcnt_q  <= '0;
                  end else begin
                     rcnt_q <= rcnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= RPT_IDLE;
                  rcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign state_o   = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Six-button conditioner: per-key debounce/repeat plus a pending-event set
// drained lowest index first over a valid/ready handshake.
module key_conditioner
   import key_pkg::*;
#(
   parameter int               DEBOUNCE_CYCLES = 270000,
   parameter int               REPEAT_DELAY    = 13500000,
   parameter int               REPEAT_RATE     = 2700000,
   parameter logic [KEY_N-1:0] REPEAT_MASK     = 6'b001111
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KEY_N-1:0]     key_n,
   output logic [KEY_N-1:0]     key_level,
   output logic [KEY_N-1:0]     key_press,
   output logic [KEY_N-1:0]     key_release,
   output logic                 evt_valid,
   output logic [CODE_W-1:0]    evt_code,
   input  logic                 evt_ready,
   output logic [2*KEY_N-1:0]   dbg_rpt_state
);

   logic [KEY_N-1:0] pending_q, pending_d;
   logic [KEY_N-1:0] clr_mask;

   for (genvar g = 0; g < KEY_N; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_key (
         .clk       (clk),
         .rst       (rst),
         .key_n_i   (key_n[g]),
         .rpt_en_i  (REPEAT_MASK[g]),
         .level_o   (key_level[g]),
         .press_o   (key_press[g]),
         .release_o (key_release[g]),
         .state_o   (dbg_rpt_state[2*g +: 2])
      );
   end

   // Handshake: an event transfers on any edge where evt_valid && evt_ready.
   // A press landing on the same edge as the handshake re-arms the bit.
   assign evt_valid = |pending_q;
   assign evt_code  = lowest_index(pending_q);

   always_comb begin
      clr_mask = '0;
      if (evt_valid && evt_ready) clr_mask[evt_code] = 1'b1;
      pending_d = (pending_q & ~clr_mask) | key_press;
   end

   always_ff @(posedge clk) begin
      if (!rst) pending_q <= '0;
      else      pending_q <= pending_d;
   end

endmodule
